// File: rtl/adder_4b.sv
// ---------------------------------------------------------------------------
// adder_4b
//   Registered 4-bit adder. The sum comes from a ripple chain of four
//   full-adder cells. The sum and its flags are captured into an output
//   register when in_valid is high.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   qualifies A, B, C0 this cycle
//   A, B       4-bit addends (unsigned or two's complement)
//   C0         carry-in
//   S          registered sum (A+B+C0) mod 16
//   C4         registered carry-out of bit 3
//   V          registered signed overflow (carry into bit 3 ^ carry out)
//   Z          registered flag, high when S == 0
//   out_valid  high for one cycle per captured valid input
// ---------------------------------------------------------------------------

// Single-bit full-adder cell used as the ripple stage.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module adder_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] S,
  output logic       C4,
  output logic       V,
  output logic       Z,
  output logic       out_valid
);
  // c[i] is the carry into bit i; c[4] is the final carry-out.
  logic [4:0] c;
  logic [3:0] sum;
  logic       v_next;
  logic       z_next;

  assign c[0] = C0;

  // Explicit ripple chain: each cell consumes the previous cell's carry.
  // Lookahead is deliberately not used.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      full_adder u_fa (
        .a  (A[gi]),
        .b  (B[gi]),
        .ci (c[gi]),
        .s  (sum[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // Signed overflow occurs when the carry into the sign bit differs from
  // the carry out of it.
  assign v_next = c[3] ^ c[4];
  // Z is based only on the 4-bit sum. A wrap to zero with C4=1 still sets Z.
  assign z_next = (sum == 4'h0);

  // Reset takes priority over in_valid. Without a valid input, the result
  // registers hold their values and only out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S         <= 4'h0;
      C4        <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S         <= sum;
      C4        <= c[4];
      V         <= v_next;
      Z         <= z_next;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_4b.sv
// ---------------------------------------------------------------------------
// tb_adder_4b
//   Self-checking bench for adder_4b. It applies a linear sequence of
//   directed steps, then an exhaustive sweep and a randomized run. Every
//   output is compared after each clock edge against a behavioural model
//   that is computed from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_adder_4b;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       C0;
  logic [3:0] S;
  logic       C4;
  logic       V;
  logic       Z;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  // Model state: the expected contents of the output registers.
  logic [3:0] exp_s;
  logic       exp_c4;
  logic       exp_v;
  logic       exp_z;
  logic       exp_ov;

  adder_4b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C0        (C0),
    .S         (S),
    .C4        (C4),
    .V         (V),
    .Z         (Z),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run ends on its own even if the sequence stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the 5-bit total comes from integer addition. Signed
  // overflow means the two's-complement result falls outside -8..7.
  task automatic model(input logic r, input logic iv, input logic [3:0] a,
                       input logic [3:0] b, input logic ci);
    int u;
    int sg;
    if (!r) begin
      exp_s = 4'h0; exp_c4 = 1'b0; exp_v = 1'b0; exp_z = 1'b0; exp_ov = 1'b0;
    end else if (iv) begin
      u      = int'(a) + int'(b) + int'(ci);
      sg     = (a >= 8 ? int'(a) - 16 : int'(a)) + (b >= 8 ? int'(b) - 16 : int'(b)) + int'(ci);
      exp_s  = 4'(u % 16);
      exp_c4 = (u >= 16);
      exp_v  = (sg > 7) || (sg < -8);
      exp_z  = ((u % 16) == 0);
      exp_ov = 1'b1;
    end else begin
      exp_ov = 1'b0;
    end
  endtask

  // One transaction: drive on the falling edge, let the rising edge capture
  // the inputs, then check the outputs 1 time unit later.
  task automatic step(input string tag, input logic r, input logic iv,
                      input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    rst_n = r; in_valid = iv; A = a; B = b; C0 = ci;
    @(posedge clk);
    model(r, iv, a, b, ci);
    #1;
    $display("%s rst_n=%0b iv=%0b A=%h B=%h C0=%0b -> S=%h C4=%0b V=%0b Z=%0b ov=%0b",
             tag, r, iv, a, b, ci, S, C4, V, Z, out_valid);
    chk({tag, ".S"},  8'(S),         8'(exp_s));
    chk({tag, ".C4"}, 8'(C4),        8'(exp_c4));
    chk({tag, ".V"},  8'(V),         8'(exp_v));
    chk({tag, ".Z"},  8'(Z),         8'(exp_z));
    chk({tag, ".ov"}, 8'(out_valid), 8'(exp_ov));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = 4'h0; B = 4'h0; C0 = 1'b0;

    // Reset wins over a valid all-ones input.
    step("reset0", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
    step("reset1", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);

    // Zero vector.
    step("zero", 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    step("idle", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

    // Back-to-back carry wraps to zero.
    step("wrap0", 1'b1, 1'b1, 4'hF, 4'h0, 1'b1);
    step("wrap1", 1'b1, 1'b1, 4'h0, 4'hF, 1'b1);
    step("wrap2", 1'b1, 1'b1, 4'hF, 4'h1, 1'b0);
    step("wrap3", 1'b1, 1'b1, 4'h1, 4'hF, 1'b0);

    // Maximum result.
    step("max", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);

    // Signed overflow.
    step("ovf_pos", 1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
    step("ovf_neg", 1'b1, 1'b1, 4'h8, 4'h8, 1'b0);

    // Hold: the result stays put while in_valid is low.
    step("hold_ld", 1'b1, 1'b1, 4'h3, 4'h4, 1'b1);
    step("hold0",   1'b1, 1'b0, 4'hA, 4'h9, 1'b1);
    step("hold1",   1'b1, 1'b0, 4'h1, 4'h2, 1'b0);

    // Reset in the middle of a stream discards the in-flight result.
    step("mid_a",   1'b1, 1'b1, 4'h5, 4'h6, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 4'h5, 4'h6, 1'b1);
    step("mid_b",   1'b1, 1'b1, 4'h2, 4'h2, 1'b0);

    // Exhaustive sweep over all {A,B,C0}, with back-to-back valid inputs.
    for (int i = 0; i < 512; i++) begin
      step("sweep", 1'b1, 1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i));
    end

    // Randomized traffic, including valid gaps and occasional resets.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
